// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: data port has priority, instruction fetch is forced
// after STARVE_LIMIT consecutive data grants while a fetch is waiting.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {IDLE, IREQ, DREQ} state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);

    state_t            state, next_state;
    logic [ADDR_W-1:0] lat_addr, lat_data, nxt_addr, nxt_data;
    logic              lat_wr, nxt_wr;
    logic [2:0]        dstreak, nxt_streak;
    logic              dreq, force_i;

    assign dreq    = dREN | dWEN;
    assign force_i = iREN & (dstreak == LIMIT);

    // The RAM address/data buses simply show the latches, so they hold between transactions.
    assign ramaddr  = lat_addr;
    assign ramstore = lat_data;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            dstreak  <= '0;
        end else begin
            state    <= next_state;
            lat_addr <= nxt_addr;
            lat_data <= nxt_data;
            lat_wr   <= nxt_wr;
            dstreak  <= nxt_streak;
        end
    end

    always_comb begin
        next_state = state;
        nxt_addr   = lat_addr;
        nxt_data   = lat_data;
        nxt_wr     = lat_wr;
        nxt_streak = dstreak;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        case (state)
            IDLE: begin
                if (force_i || (iREN && !dreq)) begin
                    next_state = IREQ;
                    nxt_addr   = iaddr;
                    nxt_streak = '0;
                end else if (dreq) begin
                    next_state = DREQ;
                    nxt_addr   = daddr;
                    nxt_data   = dstore;
                    nxt_wr     = dWEN;
                    // Streak only counts data grants that bypassed a waiting fetch.
                    if (!iREN)
                        nxt_streak = '0;
                    else if (dstreak != LIMIT)
                        nxt_streak = dstreak + 3'd1;
                end else begin
                    nxt_streak = '0;
                end
            end
            IREQ: begin
                ramREN = 1'b1;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == RS_ACCESS) begin
                    iwait      = 1'b0;
                    iload      = ramload;
                    next_state = IDLE;
                end
            end
            DREQ: begin
                ramWEN = lat_wr;
                ramREN = !lat_wr;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (ramstate == RS_ACCESS) begin
                    dwait      = 1'b0;
                    if (!lat_wr)
                        dload = ramload;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level owner model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Transaction model: who owns the RAM port, what was captured at grant,
    // and how many data grants in a row skipped a waiting fetch.
    int          owner  = 0;   // 0 none, 1 fetch, 2 data
    int          streak = 0;
    logic [31:0] m_addr = 0, m_data = 0;
    bit          m_wr   = 0;
    bit          mvalid = 0;
    string       seq    = "";

    always @(posedge CLK) begin
        cyc++;
        if (!nRST) begin
            owner = 0; streak = 0; m_addr = 0; m_data = 0; m_wr = 0; mvalid = 1;
        end else if (owner == 0) begin
            if (iREN && (streak >= LIM || !(dREN || dWEN))) begin
                owner = 1; m_addr = iaddr; streak = 0;
            end else if (dREN || dWEN) begin
                owner = 2; m_addr = daddr; m_data = dstore; m_wr = dWEN;
                streak = iREN ? ((streak + 1 > LIM) ? LIM : streak + 1) : 0;
            end else begin
                streak = 0;
            end
        end else if (owner == 1) begin
            if (!iREN || ramstate == 2'd2) owner = 0;
        end else begin
            if (!(dREN || dWEN) || ramstate == 2'd2) owner = 0;
        end
    end

    always @(negedge CLK) begin
        if (mvalid) begin
            bit          fdone, ddone, e_ren, e_wen;
            logic [31:0] e_il, e_dl;
            fdone = nRST && owner == 1 && iREN && ramstate == 2'd2;
            ddone = nRST && owner == 2 && (dREN || dWEN) && ramstate == 2'd2;
            e_ren = owner == 1 || (owner == 2 && !m_wr);
            e_wen = owner == 2 && m_wr;
            e_il  = fdone ? ramload : 32'h0;
            e_dl  = (ddone && !m_wr) ? ramload : 32'h0;
            checks++;
            if (ramREN !== e_ren || ramWEN !== e_wen || ramaddr !== m_addr ||
                ramstore !== m_data || iwait !== !fdone || dwait !== !ddone ||
                iload !== e_il || dload !== e_dl) begin
                errors++;
                $display("FAIL model cycle %0d: got ren=%b wen=%b addr=%h st=%h iw=%b dw=%b il=%h dl=%h expected ren=%b wen=%b addr=%h st=%h iw=%b dw=%b il=%h dl=%h",
                         cyc, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
                         e_ren, e_wen, m_addr, m_data, !fdone, !ddone, e_il, e_dl);
            end
            if (!iwait && !dwait) begin
                errors++;
                $display("FAIL both_ready cycle %0d: iwait=%b dwait=%b", cyc, iwait, dwait);
            end
            if (!iwait) seq = {seq, "I"};
            if (!dwait) seq = {seq, "D"};
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
        tick(); tick();
        #1;
        chk("rst_ramREN", 32'(ramREN), 0);
        chk("rst_ramWEN", 32'(ramWEN), 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", 32'(iwait), 1);
        chk("rst_dwait", 32'(dwait), 1);
        chk("rst_loads", iload | dload, 0);
        nRST = 1;
        tick();

        // Single fetch, ACCESS on the second strobe cycle
        iREN = 1; iaddr = 32'h40; ramstate = 2'd0; #1;
        chk("sf_idle_ren", 32'(ramREN), 0);
        tick(); #1;
        chk("sf_c1_ren", 32'(ramREN), 1);
        chk("sf_c1_addr", ramaddr, 32'h40);
        chk("sf_c1_iwait", 32'(iwait), 1);
        tick();
        ramstate = 2'd2; ramload = 32'h2002_0005; #1;
        chk("sf_c2_ren", 32'(ramREN), 1);
        chk("sf_c2_iwait", 32'(iwait), 0);
        chk("sf_c2_iload", iload, 32'h2002_0005);
        tick();
        iREN = 0; ramstate = 2'd0; #1;
        chk("sf_back_ren", 32'(ramREN), 0);
        chk("sf_back_iwait", 32'(iwait), 1);
        chk("sf_back_iload", iload, 0);
        tick();

        // Simultaneous fetch + write: write first, fetch on the next IDLE
        iREN = 1; iaddr = 32'h40; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramstate = 2'd2; ramload = 32'h0000_1111;
        tick(); #1;
        chk("sim_wen", 32'(ramWEN), 1);
        chk("sim_ren", 32'(ramREN), 0);
        chk("sim_addr", ramaddr, 32'h100);
        chk("sim_store", ramstore, 32'hDEAD_BEEF);
        chk("sim_dwait", 32'(dwait), 0);
        chk("sim_iwait", 32'(iwait), 1);
        tick();
        dWEN = 0;
        tick(); #1;
        chk("sim_f_ren", 32'(ramREN), 1);
        chk("sim_f_addr", ramaddr, 32'h40);
        chk("sim_f_iwait", 32'(iwait), 0);
        chk("sim_f_iload", iload, 32'h0000_1111);
        chk("sim_f_store", ramstore, 32'hDEAD_BEEF);
        tick();
        iREN = 0;
        tick();

        // Starvation: fetch pending, data always requesting
        seq = "";
        iREN = 1; iaddr = 32'h20; dREN = 1; daddr = 32'h10; ramstate = 2'd2; ramload = 32'h55;
        repeat (14) tick();
        iREN = 0; dREN = 0;
        checks++;
        if (seq != "DDDDIDD") begin
            errors++;
            $display("FAIL starve_order: got %s expected DDDDIDD", seq);
        end
        tick();

        // Data read through BUSY, ERROR, BUSY, ACCESS
        dREN = 1; daddr = 32'h200; ramstate = 2'd1;
        tick(); #1;
        chk("eb_c1_ren", 32'(ramREN), 1);
        chk("eb_c1_dwait", 32'(dwait), 1);
        tick();
        ramstate = 2'd3; #1;
        chk("eb_c2_ren", 32'(ramREN), 1);
        chk("eb_c2_dwait", 32'(dwait), 1);
        tick();
        ramstate = 2'd1; #1;
        chk("eb_c3_ren", 32'(ramREN), 1);
        tick();
        ramstate = 2'd2; ramload = 32'h1234_5678; #1;
        chk("eb_c4_ren", 32'(ramREN), 1);
        chk("eb_c4_dwait", 32'(dwait), 0);
        chk("eb_c4_dload", dload, 32'h1234_5678);
        chk("eb_c4_addr", ramaddr, 32'h200);
        tick();
        dREN = 0; ramstate = 2'd0;
        tick();

        // Fetch abort while RAM busy
        iREN = 1; iaddr = 32'h80; ramstate = 2'd1;
        tick(); #1;
        chk("ab_c1_ren", 32'(ramREN), 1);
        tick();
        iREN = 0; #1;
        chk("ab_c2_iwait", 32'(iwait), 1);
        tick(); #1;
        chk("ab_idle_ren", 32'(ramREN), 0);
        chk("ab_idle_iwait", 32'(iwait), 1);
        chk("ab_idle_addr", ramaddr, 32'h80);
        tick();

        // Reset during a data write, then a fresh fetch
        iREN = 1; iaddr = 32'h88; dWEN = 1; daddr = 32'h300; dstore = 32'hCAFE_F00D; ramstate = 2'd1;
        tick(); #1;
        chk("rm_wen", 32'(ramWEN), 1);
        nRST = 0;
        tick(); #1;
        chk("rm_wen_rst", 32'(ramWEN), 0);
        chk("rm_addr_rst", ramaddr, 0);
        chk("rm_store_rst", ramstore, 0);
        chk("rm_dwait_rst", 32'(dwait), 1);
        chk("rm_streak_rst", 32'(dut.dstreak), 0);
        nRST = 1; dWEN = 0; iaddr = 32'h44; ramstate = 2'd2; ramload = 32'hABCD_0001;
        tick(); #1;
        chk("rm_f_iwait", 32'(iwait), 0);
        chk("rm_f_addr", ramaddr, 32'h44);
        chk("rm_f_iload", iload, 32'hABCD_0001);
        tick();
        iREN = 0; ramstate = 2'd0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the instruction-fetch port and the data port from the cache side onto the single shared RAM port.
- Data requests have priority. A bounded-starvation counter guarantees forward progress for instruction fetch.
- Sequences each RAM transaction through a 3-state FSM using the RAM's ramstate handshake and returns per-port wait/load signals to the caches.

Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while iREN is pending before fetch is forced.
- ADDR_W, 32, address/data width.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  reset, synchronous, active-low
- iREN  input  1  instruction read request
- iaddr  input  ADDR_W  instruction address
- iwait  output  1  1 = fetch not complete this cycle
- iload  output  ADDR_W  fetched word; valid when iREN & ~iwait
- dREN  input  1  data read request
- dWEN  input  1  data write request; wins over dREN if both are high
- daddr  input  ADDR_W  data address
- dstore  input  ADDR_W  write data
- dwait  output  1  1 = data access not complete this cycle
- dload  output  ADDR_W  read word; valid when dREN & ~dwait
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  ADDR_W  RAM write data
- ramload  input  ADDR_W  RAM read data
- ramstate  input  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- FSM states: IDLE, IREQ, DREQ.
- Registers: state, lat_addr, lat_data, lat_wr, dstreak (3 bits, saturating at STARVE_LIMIT).
- Reset (nRST=0 at a clock edge):
  - state=IDLE, lat_addr=0, lat_data=0, lat_wr=0, dstreak=0.
  - Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
  - Reset mid-transaction abandons it; no completion pulse is emitted.
- IDLE: ram strobes are 0; iwait=dwait=1. Grant rules:
  - force_i = iREN & (dstreak==STARVE_LIMIT).
  - If force_i, or iREN & ~(dREN|dWEN): latch iaddr, go to IREQ, clear dstreak.
  - Else if dREN|dWEN: latch daddr, dstore, lat_wr=dWEN; go to DREQ. dstreak increments (saturating) if iREN=1, else clears.
  - Else stay in IDLE and clear dstreak.
- IREQ: ramREN=1, ramaddr=lat_addr.
  - ramstate==ACCESS: iwait=0 and iload=ramload in this same cycle; next state IDLE.
  - FREE or BUSY: hold.
  - ERROR: hold and retry (strobes stay asserted).
  - iREN drops before ACCESS: abort, next state IDLE, no iwait pulse.
- DREQ: ramaddr=lat_addr; ramWEN=lat_wr, ramREN=~lat_wr; ramstore=lat_data.
  - ACCESS: dwait=0 for one cycle; dload=ramload on reads; next state IDLE.
  - If dREN|dWEN drops before ACCESS: abort, as for IREQ.
- The non-granted port always sees wait=1. iwait and dwait are never both 0 in the same cycle.
- Outside the active state, ramaddr and ramstore hold their last latched values. iload and dload are 0 except in the completion cycle.
- Latency: request in IDLE at cycle N, strobe at N+1, minimum completion at N+1 (ACCESS the same cycle). Back-to-back accesses from one port therefore take 2 cycles each, with one IDLE cycle between transactions.
- Request signal changes during IREQ/DREQ are ignored, except request withdrawal (abort). Address/data are taken from the latches only.

Test Plan:
- Single fetch: iREN=1, iaddr=0x0000_0040; RAM responds ACCESS on the 2nd strobe cycle with ramload=0x2002_0005 -> ramREN=1 for 2 cycles, ramaddr=0x40, iwait=0 for exactly 1 cycle with iload=0x2002_0005, then FSM back in IDLE.
- Simultaneous request: iREN=1 and dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF; RAM ACCESS immediately -> write granted first (ramWEN=1, ramstore=0xDEADBEEF, dwait pulse). The fetch is granted on the next IDLE.
- Starvation: iREN held high; dREN re-asserted every IDLE cycle; RAM ACCESS immediately -> exactly 4 data grants, then one instruction grant (iwait=0), then data grants resume.
- ERROR/BUSY: DREQ read; ramstate sequence BUSY, ERROR, BUSY, ACCESS (ramload=0x1234_5678) -> ramREN held all 4 cycles, dwait=0 only in the 4th cycle, dload=0x12345678.
- Abort: IREQ with ramstate=BUSY; iREN drops at cycle 2 -> state IDLE next cycle, ramREN=0, iwait never 0.
- Reset mid-operation: nRST=0 during DREQ write -> next edge all outputs take reset values, dstreak=0, no dwait pulse. After release, a new iREN is granted normally.
